cpu_clock_ctrl: RTL and testbench

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

---
 rtl/cpu_clock_ctrl_if.sv | 46 ++++
 rtl/cpu_clock_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clock_ctrl_if.sv
// Control and status bundle for the CPU clock controller.
// Signalling: run_i, halt_i and clear_i are levels sampled on every rising
// clk edge; div_load is a one-cycle strobe qualifying div_i; step_i is a raw
// asynchronous button level; cpu_en is a registered one-cycle enable pulse.
interface cpu_clock_ctrl_if #(
    parameter int DIV_W = 32
);
    logic             run_i;
    logic             step_i;
    logic             halt_i;
    logic             clear_i;
    logic             div_load;
    logic [DIV_W-1:0] div_i;
    logic             cpu_en;
    logic             clk_slow;
    logic [1:0]       state_o;
    logic [15:0]      en_cnt;

    // Side that issues requests and observes the enable stream.
    modport master (
        output run_i,
        output step_i,
        output halt_i,
        output clear_i,
        output div_load,
        output div_i,
        input  cpu_en,
        input  clk_slow,
        input  state_o,
        input  en_cnt
    );

    // The clock controller itself.
    modport slave (
        input  run_i,
        input  step_i,
        input  halt_i,
        input  clear_i,
        input  div_load,
        input  div_i,
        output cpu_en,
        output clk_slow,
        output state_o,
        output en_cnt
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: free-running divided enable (RUN), single-step
// from a debounced-by-synchroniser button (STEP), and a processor HALT that
// only clear_i can release. The FSM state is visible on state_o.
module cpu_clock_ctrl #(
    parameter int DIV_W       = 32,
    parameter int DIV_DEFAULT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_clock_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             cpu_en_q;
    logic             cpu_en_next;
    logic             clk_slow_q;
    logic [15:0]      en_cnt_q;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             step_edge;

    // Two-flop synchroniser for the raw button plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.step_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A step request is the rising edge of the synchronised button.
    assign step_edge = s2 & ~s3;

    // Next-state, counter and enable decode; a divisor load overrides the counter.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        div_next    = div_reg;
        cpu_en_next = 1'b0;
        case (state)
            ST_STOP: begin
                cnt_next = '0;
                if (bus.halt_i) begin
                    state_next = ST_HALT;
                end else if (bus.run_i) begin
                    state_next = ST_RUN;
                end else if (step_edge) begin
                    state_next  = ST_STEP;
                    cpu_en_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt_i) begin
                    state_next = ST_HALT;
                    cnt_next   = '0;
                end else if (!bus.run_i) begin
                    state_next = ST_STOP;
                    cnt_next   = '0;
                end else if (cnt == div_reg) begin
                    cnt_next    = '0;
                    cpu_en_next = 1'b1;
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end
            ST_STEP: begin
                cnt_next   = '0;
                state_next = bus.halt_i ? ST_HALT : ST_STOP;
            end
            ST_HALT: begin
                cnt_next = '0;
                if (!bus.halt_i && bus.clear_i) begin
                    state_next = ST_STOP;
                end
            end
            default: begin
                state_next = ST_STOP;
                cnt_next   = '0;
            end
        endcase
        // A new divisor restarts the period; the pulse due this cycle in RUN is dropped.
        if (bus.div_load) begin
            div_next = bus.div_i;
            cnt_next = '0;
            if (state == ST_RUN) begin
                cpu_en_next = 1'b0;
            end
        end
    end

    // State, counter, divisor and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_STOP;
            cnt        <= '0;
            div_reg    <= DIV_W'(DIV_DEFAULT);
            cpu_en_q   <= 1'b0;
            clk_slow_q <= 1'b0;
            en_cnt_q   <= 16'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            div_reg  <= div_next;
            cpu_en_q <= cpu_en_next;
            if (cpu_en_next) begin
                clk_slow_q <= ~clk_slow_q;
                en_cnt_q   <= en_cnt_q + 16'd1;
            end
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.clk_slow = clk_slow_q;
    assign bus.state_o  = state;
    assign bus.en_cnt   = en_cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the enable stream.
module tb_cpu_clock_ctrl;

    localparam int DIV_W       = 32;
    localparam int DIV_DEFAULT = 1;

    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    cpu_clock_ctrl_if #(.DIV_W(DIV_W)) bus ();

    cpu_clock_ctrl #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural model: mode, edges left until next pulse, divisor, pulse tally.
    int              m_mode;
    longint          m_left;
    longint          m_div;
    int              m_pulses;
    bit              m_en;
    bit              m_slow;
    bit              hist[3];   // step_i as sampled 1, 2 and 3 edges ago

    // Scoreboard: {state, cpu_en, clk_slow, en_cnt}
    logic [19:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_STOP;
        m_left   = 0;
        m_div    = DIV_DEFAULT;
        m_pulses = 0;
        m_en     = 1'b0;
        m_slow   = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs now on the bus.
    task automatic model_edge();
        bit pressed;
        bit pulse;
        int nxt;
        pressed = hist[1] && !hist[2];
        pulse   = 1'b0;
        nxt     = m_mode;
        case (m_mode)
            M_STOP: begin
                if (bus.halt_i) nxt = M_HALT;
                else if (bus.run_i) begin
                    nxt    = M_RUN;
                    m_left = m_div + 1;
                end else if (pressed) begin
                    nxt   = M_STEP;
                    pulse = 1'b1;
                end
            end
            M_RUN: begin
                if (bus.halt_i) nxt = M_HALT;
                else if (!bus.run_i) nxt = M_STOP;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        pulse  = 1'b1;
                        m_left = m_div + 1;
                    end
                end
            end
            M_STEP: nxt = bus.halt_i ? M_HALT : M_STOP;
            default: if (!bus.halt_i && bus.clear_i) nxt = M_STOP;
        endcase
        if (bus.div_load) begin
            m_div  = longint'(bus.div_i);
            m_left = m_div + 1;
            if (m_mode == M_RUN) pulse = 1'b0;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = bus.step_i;
        m_mode  = nxt;
        m_en    = pulse;
        if (pulse) begin
            m_slow   = ~m_slow;
            m_pulses = (m_pulses + 1) % 65536;
        end
    endtask

    // Driver: one clock with the current inputs, then score the outputs.
    task automatic tick();
        logic [19:0] e;
        model_edge();
        exp_q.push_back({2'(m_mode), m_en, m_slow, 16'(m_pulses)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("state", 32'(bus.state_o), 32'(e[19:18]));
        check_eq("cpu_en", 32'(bus.cpu_en), 32'(e[17]));
        check_eq("clk_slow", 32'(bus.clk_slow), 32'(e[16]));
        check_eq("en_cnt", 32'(bus.en_cnt), 32'(e[15:0]));
    endtask

    task automatic clear_inputs();
        bus.run_i    = 1'b0;
        bus.step_i   = 1'b0;
        bus.halt_i   = 1'b0;
        bus.clear_i  = 1'b0;
        bus.div_load = 1'b0;
        bus.div_i    = '0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'(bus.state_o), 32'd0);
        check_eq("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check_eq("rst_clk_slow", 32'(bus.clk_slow), 32'd0);
        check_eq("rst_en_cnt", 32'(bus.en_cnt), 32'd0);
        clear_inputs();
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Continuous run at the default divisor: pulse every 2nd cycle.
        bus.run_i = 1'b1;
        repeat (11) tick();
        check_eq("run_en_cnt_5", 32'(bus.en_cnt), 32'd5);

        // Divisor changes while running.
        bus.div_load = 1'b1;
        bus.div_i    = 3;
        tick();
        bus.div_load = 1'b0;
        repeat (12) tick();
        bus.div_load = 1'b1;
        bus.div_i    = 0;
        tick();
        bus.div_load = 1'b0;
        repeat (5) begin
            tick();
            check_eq("div0_en_const", 32'(bus.cpu_en), 32'd1);
        end

        // Halt with run held, clear blocked by halt, then released.
        bus.halt_i = 1'b1;
        tick();
        bus.halt_i = 1'b0;
        check_eq("halt_entered", 32'(bus.state_o), 32'd3);
        repeat (4) tick();
        bus.halt_i  = 1'b1;
        bus.clear_i = 1'b1;
        tick();
        check_eq("clear_vs_halt", 32'(bus.state_o), 32'd3);
        bus.halt_i = 1'b0;
        tick();
        check_eq("clear_release", 32'(bus.state_o), 32'd0);
        bus.clear_i = 1'b0;
        bus.run_i   = 1'b0;
        repeat (3) tick();

        // Single step from a wide button press.
        do_reset();
        bus.step_i = 1'b1;
        repeat (5) tick();
        bus.step_i = 1'b0;
        repeat (5) tick();
        check_eq("step_en_cnt_1", 32'(bus.en_cnt), 32'd1);
        check_eq("step_back_stop", 32'(bus.state_o), 32'd0);

        // Reset in the middle of a long count, then resume at the default divisor.
        bus.run_i    = 1'b1;
        bus.div_load = 1'b1;
        bus.div_i    = 5;
        tick();
        bus.div_load = 1'b0;
        repeat (3) tick();
        do_reset();
        bus.run_i = 1'b1;
        repeat (6) tick();
        bus.run_i = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.run_i = ~bus.run_i;
            if ($urandom_range(0, 5) == 0) bus.step_i = ~bus.step_i;
            bus.halt_i   = ($urandom_range(0, 39) == 0);
            bus.clear_i  = ($urandom_range(0, 9) == 0);
            bus.div_load = ($urandom_range(0, 49) == 0);
            bus.div_i    = DIV_W'($urandom_range(0, 6));
            tick();
        end

        // en_cnt wrap after 65536 pulses at divisor 0.
        do_reset();
        bus.div_load = 1'b1;
        bus.div_i    = 0;
        tick();
        bus.div_load = 1'b0;
        bus.run_i    = 1'b1;
        tick();
        repeat (65535) tick();
        check_eq("en_cnt_ffff", 32'(bus.en_cnt), 32'h0000_ffff);
        tick();
        check_eq("en_cnt_wrap", 32'(bus.en_cnt), 32'd0);
        bus.run_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
